last_data_reader: RTL and testbench
===================================

# last_data_reader

Read-side responder for the last-data store. It captures the packed five-entry last-data vector into a local snapshot when told to. It serves single-entry read requests from four ports through a round-robin arbiter and returns each result one cycle after acceptance. It sits between the last-data writer and the four per-port consumers.

## Interface
- DATA_W, 20, width of one entry
- ENTRIES, 5, number of valid entries in the snapshot; addresses 0..ENTRIES-1
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- snap_i  input  ENTRIES*DATA_W  packed last-data vector; entry k at bits [k*DATA_W +: DATA_W]
- snap_load  input  1  capture snap_i into the snapshot at the next edge
- rd_req  input  4  per-port read request; held until acknowledged
- rd_addr  input  16  per-port entry address; port p at bits [p*4 +: 4]; stable while rd_req[p]
- rd_ack  output  4  one-hot, combinational; request accepted this cycle
- rd_valid  output  4  one-hot, registered; response for port p is present
- rd_data  output  DATA_W  response data, shared by all ports
- rd_err  output  1  response address was out of range

## Operation
- Snapshot: ENTRIES registers of DATA_W bits, all 0 at reset; snap_load=1 loads all entries from snap_i at the edge.
- Arbitration: each cycle, at most one port p with rd_req[p]=1 is chosen round-robin; rd_ack[p]=1 in that same cycle.
- Round-robin pointer: 2 bits, reset 0, so priority order is 0,1,2,3. After a grant to port w the pointer becomes (w+1) mod 4, i.e. the search starts from w+1. With no grant the pointer holds.
- Response: at the edge ending the ack cycle, rd_valid is set to onehot(w).
  - If rd_addr[w] < ENTRIES: rd_data = snapshot[rd_addr[w]], rd_err = 0.
  - Otherwise (5..15): rd_data = 0, rd_err = 1.
- Idle: with no grant, rd_valid goes to 0 and rd_data/rd_err hold their last values.
- Requester protocol:
  - A port deasserts rd_req, or presents a new address, in the cycle after its rd_ack.
  - A request dropped before ack is legal and is ignored.
- No backpressure on responses: a consumer must accept rd_valid in the cycle it is high.

## Timing
- Reset values: rd_valid=0, rd_data=0, rd_err=0, snapshot=0, pointer=0.
- While rst=0, rd_ack is forced to 0.
- Read latency is one cycle: ack in cycle N, rd_valid/rd_data in cycle N+1.
- Throughput is one response per cycle, back-to-back across ports or from the same port.
- snap_load in the same cycle as an ack: the response uses the pre-load snapshot. A request acked in the next cycle sees the new data.
- All four ports requesting continuously: grants follow 0,1,2,3,0,… with exactly one grant per cycle. A port waits at most 3 cycles between grants.
- A single requester is granted every cycle it requests, regardless of pointer position.
- Reset mid-operation:
  - A pending response is dropped; rd_valid falls asynchronously.
  - After release, arbitration restarts at port 0.
- Address bits are sampled only in the ack cycle.

## Structure
- Package ld_pkg: DATA_W, ENTRIES, NPORTS=4, ADDR_W=4, typedef port_idx_t (2-bit), typedef entry_t (DATA_W-bit).
- Sub-module rr_arbiter4:
  - Inputs: req[3:0], clk, rst.
  - Outputs: combinational one-hot gnt and the encoded winner index.
  - Owns the pointer register.
- Top level contains the snapshot registers, the address mux, the range check and the response register.

## Test plan
- Reset and load: with rst=0 and rd_req=4'b1111, all outputs are 0 and rd_ack=0. Release rst, apply snap_load with entries 0..4 = 20'h00001, 20'h00002, 20'h00003, 20'h00004, 20'h00005. Port 2 reads addr 3 -> rd_valid=4'b0100 and rd_data=20'h00004 one cycle after ack.
- Round-robin: all four ports request continuously with addr = port number -> acks 0001,0010,0100,1000,0001. Responses: data 1,2,3,4,1 on consecutive cycles.
- Out of range: port 1 reads addr 4'h7 -> rd_err=1, rd_data=0, rd_valid=4'b0010. A following read of addr 4 gives rd_err=0, data 20'h00005.
- Load collision: snap_load with entry 0 = 20'hABCDE in the same cycle port 0 is acked for addr 0 -> response is the old 20'h00001. The next read returns 20'hABCDE.
- Reset mid-response: assert rst while rd_valid=4'b1000 -> rd_valid drops to 0 immediately. After release, with ports 1 and 3 requesting, port 1 is granted first.
- Single requester streaming: port 3 alone requests for 4 cycles with addrs 0,1,2,3 -> four back-to-back acks and responses 1,2,3,4.

Source files
------------

// File: rtl/ld_pkg.sv
// Shared parameters and types for the last-data read path.
package ld_pkg;
    localparam int DATA_W  = 20;
    localparam int ENTRIES = 5;
    localparam int NPORTS  = 4;
    localparam int ADDR_W  = 4;

    typedef logic [1:0]        port_idx_t;
    typedef logic [DATA_W-1:0] entry_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter; search starts at the port after the last winner.
module rr_arbiter4
    import ld_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output port_idx_t  win
);
    port_idx_t  ptr;
    port_idx_t  idx;
    logic       found;
    logic [3:0] req_q;

    // Nothing is granted while reset is held.
    assign req_q = req & {4{rst}};

    always_comb begin
        gnt   = '0;
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            idx = ptr + port_idx_t'(i);
            if (!found && req_q[idx]) begin
                found    = 1'b1;
                win      = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (|gnt)
            ptr <= win + 2'd1;
    end
endmodule

// File: rtl/last_data_reader.sv
// Snapshot of the last-data vector served to four ports with one-cycle reads.
module last_data_reader
    import ld_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ENTRIES*DATA_W-1:0] snap_i,
    input  logic                      snap_load,
    input  logic [NPORTS-1:0]         rd_req,
    input  logic [NPORTS*ADDR_W-1:0]  rd_addr,
    output logic [NPORTS-1:0]         rd_ack,
    output logic [NPORTS-1:0]         rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_err
);
    entry_t              snap [ENTRIES];
    port_idx_t           win;
    logic [ADDR_W-1:0]   addr;
    logic                in_range;
    entry_t              mux_data;

    rr_arbiter4 u_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .gnt (rd_ack),
        .win (win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < ENTRIES; k++)
                snap[k] <= '0;
        end else if (snap_load) begin
            for (int k = 0; k < ENTRIES; k++)
                snap[k] <= snap_i[k*DATA_W +: DATA_W];
        end
    end

    assign addr     = rd_addr[win*ADDR_W +: ADDR_W];
    assign in_range = addr < ADDR_W'(ENTRIES);

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < ENTRIES; k++)
            if (addr == ADDR_W'(k))
                mux_data = snap[k];
    end

    // Snapshot read here is the pre-load value when a load shares the ack cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= '0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else if (|rd_ack) begin
            rd_valid <= rd_ack;
            rd_data  <= in_range ? mux_data : '0;
            rd_err   <= !in_range;
        end else begin
            rd_valid <= '0;
        end
    end
endmodule

// File: tb/tb_last_data_reader.sv
// Scoreboard bench for last_data_reader: directed reads, monitor checks responses.
module tb_last_data_reader;
    import ld_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [ENTRIES*DATA_W-1:0] snap_i = '0;
    logic                      snap_load = 1'b0;
    logic [3:0]                rd_req = '0;
    logic [15:0]               rd_addr = '0;
    logic [3:0]                rd_ack;
    logic [3:0]                rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic                      rd_err;

    typedef struct {
        int          due;
        logic [3:0]  vld;
        logic [19:0] dat;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   vecs = 0;
    int   bad  = 0;
    int   cyc  = 0;
    logic done = 1'b0;

    last_data_reader dut (
        .clk       (clk),
        .rst       (rst),
        .snap_i    (snap_i),
        .snap_load (snap_load),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_err    (rd_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (q.size() != 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            vecs++;
            if (rd_valid !== e.vld || rd_data !== e.dat
                || rd_err !== e.err) begin
                bad++;
                $display("FAIL resp@%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b",
                         cyc, rd_valid, rd_data, rd_err,
                         e.vld, e.dat, e.err);
            end
        end else if (!done && rd_valid !== 4'b0) begin
            vecs++;
            bad++;
            $display("FAIL idle@%0d: got v=%b want 0000", cyc, rd_valid);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic step(input logic [3:0] req, input logic [15:0] addr,
                        input logic ld, input logic [3:0] eack,
                        input logic [19:0] edat, input logic eerr,
                        input logic push);
        rd_req    = req;
        rd_addr   = addr;
        snap_load = ld;
        @(negedge clk);
        chk("ack", {28'b0, rd_ack}, {28'b0, eack});
        if (push && eack != 4'b0)
            q.push_back('{cyc + 1, eack, edat, eerr});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ENTRIES*DATA_W-1:0] pack(
        input logic [19:0] e0, input logic [19:0] e1,
        input logic [19:0] e2, input logic [19:0] e3,
        input logic [19:0] e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    initial begin
        rd_req = 4'b1111;
        #12;
        chk("rst_ack", {28'b0, rd_ack}, 32'h0);
        chk("rst_vld", {28'b0, rd_valid}, 32'h0);
        chk("rst_dat", {12'b0, rd_data}, 32'h0);
        chk("rst_err", {31'b0, rd_err}, 32'h0);
        rd_req = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        snap_i = pack(20'h1, 20'h2, 20'h3, 20'h4, 20'h5);
        step(4'b0000, 16'h0, 1, 4'b0000, 20'h0, 0, 1);
        step(4'b0100, 16'h0300, 0, 4'b0100, 20'h4, 0, 1);
        step(4'b1000, 16'h0000, 0, 4'b1000, 20'h1, 0, 1);

        step(4'b1111, 16'h3210, 0, 4'b0001, 20'h1, 0, 1);
        step(4'b1111, 16'h3210, 0, 4'b0010, 20'h2, 0, 1);
        step(4'b1111, 16'h3210, 0, 4'b0100, 20'h3, 0, 1);
        step(4'b1111, 16'h3210, 0, 4'b1000, 20'h4, 0, 1);
        step(4'b1111, 16'h3210, 0, 4'b0001, 20'h1, 0, 1);

        step(4'b0010, 16'h0070, 0, 4'b0010, 20'h0, 1, 1);
        step(4'b0010, 16'h0040, 0, 4'b0010, 20'h5, 0, 1);
        step(4'b0000, 16'h0000, 0, 4'b0000, 20'h0, 0, 1);

        step(4'b1000, 16'h0000, 0, 4'b1000, 20'h1, 0, 1);
        step(4'b1000, 16'h1000, 0, 4'b1000, 20'h2, 0, 1);
        step(4'b1000, 16'h2000, 0, 4'b1000, 20'h3, 0, 1);
        step(4'b1000, 16'h3000, 0, 4'b1000, 20'h4, 0, 1);

        snap_i = pack(20'hABCDE, 20'h2, 20'h3, 20'h4, 20'h5);
        step(4'b0001, 16'h0000, 1, 4'b0001, 20'h1, 0, 1);
        step(4'b0001, 16'h0000, 0, 4'b0001, 20'hABCDE, 0, 1);

        step(4'b1000, 16'h2000, 0, 4'b1000, 20'h0, 0, 0);
        rd_req = '0;
        chk("pre_rst_vld", {28'b0, rd_valid}, 32'h8);
        chk("pre_rst_dat", {12'b0, rd_data}, 32'h3);
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", {28'b0, rd_valid}, 32'h0);
        chk("mid_rst_dat", {12'b0, rd_data}, 32'h0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(4'b1010, 16'h3010, 0, 4'b0010, 20'h0, 0, 1);
        step(4'b1000, 16'h3000, 0, 4'b1000, 20'h0, 0, 1);
        step(4'b0000, 16'h0000, 0, 4'b0000, 20'h0, 0, 1);
        step(4'b0000, 16'h0000, 0, 4'b0000, 20'h0, 0, 1);

        done = 1'b1;
        vecs++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
